fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the show-ahead FIFO. On a start command it pops a programmed number of words from the FIFO, optionally decimating by a skip factor, and presents them as a framed valid/ready stream with start-of-packet and end-of-packet markers. A 2-entry output buffer absorbs downstream back-pressure without stalling the FIFO read timing. It sits between the FIFO read port (`rd_i` / `empty_o` / `rddata_o` / `shift_i`) and any downstream consumer.

## Interface

Parameters:
- `DWIDTH`, default 8: data word width; matches the FIFO.
- `AWIDTH`, default 4: FIFO address width; width of the skip / shift field.
- `LENWIDTH`, default 8: packet length counter width.

Ports:
- `clk_i`, input, 1: single clock; all logic on the rising edge.
- `srst_n_i`, input, 1: synchronous reset, active-low.
- `start_i`, input, 1: start a packet; sampled only in IDLE.
- `pkt_len_i`, input, LENWIDTH: words to emit; latched on an accepted start.
- `skip_i`, input, AWIDTH: read-pointer advance per pop; latched on an accepted start; 0 is treated as 1.
- `busy_o`, output, 1: high in RUN and DRAIN.
- `done_o`, output, 1: one-cycle pulse when a packet completes.
- `fifo_empty_i`, input, 1: FIFO empty flag.
- `fifo_rddata_i`, input, DWIDTH: FIFO head word, show-ahead (valid whenever not empty).
- `fifo_rd_o`, output, 1: FIFO pop strobe.
- `fifo_shift_o`, output, AWIDTH: FIFO read-pointer increment; equals the latched skip.
- `data_o`, output, DWIDTH: stream data.
- `valid_o`, output, 1: stream valid.
- `sop_o`, output, 1: first word of the packet, qualified by `valid_o`.
- `eop_o`, output, 1: last word of the packet, qualified by `valid_o`.
- `ready_i`, input, 1: stream ready.

## Operation

- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start_i`.
  - Latch `pkt_len_i` into the remaining counter.
  - Latch the effective skip (`skip_i`, or 1 when `skip_i` is 0).
  - Set the first-word flag.
- IDLE with `start_i` and `pkt_len_i` = 0: go straight to DRAIN; no FIFO reads occur.
- RUN:
  - `fifo_rd_o` = RUN & ~`fifo_empty_i` & (remaining != 0) & (buffer count < 2). It is combinational and independent of `ready_i`.
  - On each pop: write `fifo_rddata_i` into the buffer tail together with its sop/eop tags, and decrement remaining.
  - sop tag = first-word flag, which is then cleared. eop tag = (remaining == 1).
- RUN -> DRAIN on the pop that takes remaining to 0.
- DRAIN -> IDLE when the buffer is empty. `done_o` pulses for one cycle coinciding with the IDLE entry. For `pkt_len` 0, this happens one cycle after the start.
- `start_i` while busy is ignored and not queued.
- Output buffer:
  - 2 entries, FIFO-ordered.
  - The head drives `data_o`, `sop_o` and `eop_o`; `valid_o` = (count != 0).
  - Pop on `valid_o` & `ready_i`. A push and a pop in the same cycle leave the count unchanged.
- While `valid_o` is high and `ready_i` is low, `data_o`, `sop_o` and `eop_o` hold stable.
- `fifo_shift_o` holds the latched skip in all states; it changes only on an accepted start.
- Upstream guarantees FIFO occupancy ≥ skip whenever it sets skip > 1; this block does not check it.
- `LENWIDTH` counter: no wrap; the maximum packet is 2^LENWIDTH-1 words.

## Timing

- Reset values:
  - `fifo_rd_o` 0, `fifo_shift_o` 1.
  - `busy_o` 0, `done_o` 0.
  - `valid_o` 0, `data_o` 0, `sop_o` 0, `eop_o` 0.
  - FSM in IDLE, buffer count 0.
- Start latency: `start_i` at edge N puts the FSM in RUN after edge N; the first `fifo_rd_o` can occur in cycle N+1.
- Read-to-output latency: a pop in cycle M gives `valid_o` with that word in cycle M+1.
- Throughput: with `ready_i` held high and the FIFO non-empty, 1 word per cycle sustained.
- Back-pressure: with `ready_i` low, at most 2 pops occur before `fifo_rd_o` deasserts. Reads resume in the cycle after a pop frees an entry.
- An empty FIFO mid-packet stalls reads with no other effect.
- Reset mid-packet:
  - Next edge returns all state to reset values and discards buffered words.
  - No `done_o` pulse.
  - FIFO contents are not touched beyond pops already issued.

## Test plan

- FIFO preloaded with 0x10..0x14; start with `pkt_len` 5, skip 1, `ready_i` = 1. Required: 5 consecutive `fifo_rd_o` cycles, then stream 0x10..0x14 on consecutive cycles. `sop_o` is set on 0x10 and `eop_o` on 0x14. `done_o` pulses once, 1 cycle after 0x14 transfers.
- Same preload with `ready_i` held low for 6 cycles, then high. Required: exactly 2 pops, then `fifo_rd_o` = 0; `data_o` stays 0x10 stable. After release, the output order is intact with no loss or duplicate.
- FIFO preloaded with 0x00..0x0B; start with `pkt_len` 4, skip 3. Required: `fifo_shift_o` = 3 and the stream is 0x00, 0x03, 0x06, 0x09. Start with skip 0: `fifo_shift_o` = 1.
- Start with `pkt_len` 0. Required: no `fifo_rd_o` and no `valid_o`; `done_o` pulses 1 cycle after the start. Start with `pkt_len` 1: a single word with `sop_o` and `eop_o` both set.
- FIFO empty for 3 cycles mid-packet, then refilled. Required: reads pause and resume, and eop lands on the pkt_len-th word. A `start_i` pulse during RUN has no effect.
- `srst_n_i` low for 1 cycle with 2 words buffered. Required: all outputs return to reset values the next cycle, no `done_o`, and a following start runs normally.

Source files
------------

// File: rtl/fifo_stream_reader.sv
`default_nettype none
//==============================================================================
// Module      : fifo_stream_reader
// Description : Drains a programmed number of words from a show-ahead FIFO,
//               optionally decimated, into a framed valid/ready stream.
// Revision    : 1.0 - initial release
//==============================================================================
module fifo_stream_reader #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int LENWIDTH = 8
) (
    input  logic                clk_i,
    input  logic                srst_n_i,
    input  logic                start_i,
    input  logic [LENWIDTH-1:0] pkt_len_i,
    input  logic [AWIDTH-1:0]   skip_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                fifo_empty_i,
    input  logic [DWIDTH-1:0]   fifo_rddata_i,
    output logic                fifo_rd_o,
    output logic [AWIDTH-1:0]   fifo_shift_o,
    output logic [DWIDTH-1:0]   data_o,
    output logic                valid_o,
    output logic                sop_o,
    output logic                eop_o,
    input  logic                ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [LENWIDTH-1:0] r_remaining;
    logic [AWIDTH-1:0]   r_skip;
    logic                r_first;
    logic                r_done;

    logic [DWIDTH-1:0]   r_buf_data [2];
    logic [1:0]          r_buf_sop;
    logic [1:0]          r_buf_eop;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_push;
    logic                w_pop;

    // Pops depend only on buffer space, never on ready_i, so FIFO read timing
    // is decoupled from downstream back-pressure.
    assign w_push = (r_state == ST_RUN) && !fifo_empty_i &&
                    (r_remaining != '0) && (r_count != 2'd2);
    assign w_pop  = (r_count != 2'd0) && ready_i;

    assign fifo_rd_o    = w_push;
    assign fifo_shift_o = r_skip;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign valid_o      = (r_count != 2'd0);
    assign data_o       = r_buf_data[r_rd_ptr];
    assign sop_o        = r_buf_sop[r_rd_ptr];
    assign eop_o        = r_buf_eop[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_skip      <= AWIDTH'(1);
            r_first     <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
            r_buf_sop   <= '0;
            r_buf_eop   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_done <= 1'b0;

            if (w_push) begin
                r_buf_data[r_wr_ptr] <= fifo_rddata_i;
                r_buf_sop[r_wr_ptr]  <= r_first;
                r_buf_eop[r_wr_ptr]  <= (r_remaining == LENWIDTH'(1));
                r_wr_ptr             <= ~r_wr_ptr;
                r_remaining          <= r_remaining - LENWIDTH'(1);
                r_first              <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_remaining <= pkt_len_i;
                        r_skip      <= (skip_i == '0) ? AWIDTH'(1) : skip_i;
                        r_first     <= 1'b1;
                        r_state     <= (pkt_len_i == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_push && (r_remaining == LENWIDTH'(1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == 2'd0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
//==============================================================================
// Module      : tb_fifo_stream_reader
// Description : Self-checking bench: FIFO environment, packet-level reference
//               model, vector table, corner sequences and random packets.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fifo_stream_reader;

    localparam int MEMSZ = 4096;

    logic       clk = 1'b0;
    logic       srst_n;
    logic       start;
    logic [7:0] pkt_len;
    logic [3:0] skip;
    logic       busy;
    logic       done;
    logic       fifo_empty;
    logic [7:0] fifo_rddata;
    logic       fifo_rd;
    logic [3:0] fifo_shift;
    logic [7:0] data;
    logic       valid;
    logic       sop;
    logic       eop;
    logic       ready;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DWIDTH(8), .AWIDTH(4), .LENWIDTH(8)) dut (
        .clk_i         (clk),
        .srst_n_i      (srst_n),
        .start_i       (start),
        .pkt_len_i     (pkt_len),
        .skip_i        (skip),
        .busy_o        (busy),
        .done_o        (done),
        .fifo_empty_i  (fifo_empty),
        .fifo_rddata_i (fifo_rddata),
        .fifo_rd_o     (fifo_rd),
        .fifo_shift_o  (fifo_shift),
        .data_o        (data),
        .valid_o       (valid),
        .sop_o         (sop),
        .eop_o         (eop),
        .ready_i       (ready)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } word_t;

    typedef struct {
        int         len;
        int         skip;
        int         base;
        int         exp_shift;
        int         exp_pops;
        int         exp_words;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // FIFO environment
    logic [7:0] mem [MEMSZ];
    int rd_ptr = 0;
    int wr_ptr = 0;
    bit force_empty = 1'b0;
    bit rand_mode   = 1'b0;

    // Packet-level reference model
    bit    m_active = 1'b0;
    bit    m_done   = 1'b0;
    int    m_len    = 0;
    int    m_pops   = 0;
    int    m_xfers  = 0;
    int    m_shift  = 1;
    word_t exp_q[$];

    bit         hold_pend = 1'b0;
    logic [7:0] hold_d;
    logic       hold_sop, hold_eop;

    int         n_pops, n_done, n_words;
    logic [7:0] first_w, last_w;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty  = force_empty || (rd_ptr >= wr_ptr);
        fifo_rddata = mem[rd_ptr % MEMSZ];
    endtask

    task automatic load_fifo(input int base, input int avail, input bit rnd);
        for (int i = 0; i < MEMSZ; i++) begin
            mem[i] = rnd ? 8'($urandom) : 8'(base + i);
        end
        rd_ptr = 0;
        wr_ptr = avail;
        drive_fifo();
    endtask

    task automatic clear_stats();
        n_pops = 0; n_done = 0; n_words = 0; first_w = '0; last_w = '0;
    endtask

    // One clock cycle: check this cycle's outputs, take the edge, update model.
    task automatic cycle();
        logic       s_rd, s_hs, s_start, s_rst, was_active, fin;
        logic [3:0] s_skip, s_shift;
        int         s_len;
        word_t      w;
        #1;
        s_rd    = fifo_rd;
        s_hs    = valid & ready;
        s_start = start;
        s_rst   = srst_n;
        s_skip  = skip;
        s_len   = int'(pkt_len);
        s_shift = fifo_shift;

        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
        chk("fifo_shift", int'(fifo_shift), m_shift);
        chk("fifo_rd", int'(s_rd),
            int'(m_active && (m_pops < m_len) && !fifo_empty && ((m_pops - m_xfers) < 2)));
        chk("valid", int'(valid), int'((m_pops - m_xfers) > 0));
        if (hold_pend) begin
            chk("hold_data", int'(data), int'(hold_d));
            chk("hold_sop", int'(sop), int'(hold_sop));
            chk("hold_eop", int'(eop), int'(hold_eop));
        end
        if (s_hs) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_word actual=0x%0h required=none", data);
            end else begin
                w = exp_q.pop_front();
                chk("stream_data", int'(data), int'(w.d));
                chk("stream_sop", int'(sop), int'(w.sop));
                chk("stream_eop", int'(eop), int'(w.eop));
            end
            n_words++;
            if (n_words == 1) first_w = data;
            last_w = data;
        end
        if (s_rd) n_pops++;
        if (done) n_done++;
        hold_pend = valid && !ready;
        hold_d    = data;
        hold_sop  = sop;
        hold_eop  = eop;

        @(posedge clk);
        #1;
        if (s_rd) rd_ptr += int'(s_shift);
        if (!s_rst) begin
            m_active = 1'b0; m_done = 1'b0; m_len = 0; m_pops = 0; m_xfers = 0;
            m_shift = 1; hold_pend = 1'b0;
            exp_q.delete();
        end else begin
            was_active = m_active;
            fin = m_active && (m_pops == m_len) && (m_xfers == m_len);
            if (s_rd) m_pops++;
            if (s_hs) m_xfers++;
            if (fin) m_active = 1'b0;
            m_done = fin;
            if (s_start && !was_active) begin
                m_active = 1'b1;
                m_len    = s_len;
                m_pops   = 0;
                m_xfers  = 0;
                m_shift  = (s_skip == 4'd0) ? 1 : int'(s_skip);
                for (int i = 0; i < m_len; i++) begin
                    w.d   = mem[(rd_ptr + i * m_shift) % MEMSZ];
                    w.sop = (i == 0);
                    w.eop = (i == m_len - 1);
                    exp_q.push_back(w);
                end
            end
        end
        if (rand_mode) begin
            ready       = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
        end
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic start_pkt(input int len, input int sk);
        pkt_len = 8'(len);
        skip    = 4'(sk);
        start   = 1'b1;
        cycle();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || m_done) && (n < budget)) begin
            cycle();
            n++;
        end
        checks++;
        if (m_active || m_done) begin
            failures++;
            $display("FAIL idle_timeout actual=busy after %0d cycles required=idle", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   rlen;
        vecs[0] = '{5, 1, 'h10, 1, 5, 5, 8'h10, 8'h14};
        vecs[1] = '{4, 3, 'h00, 3, 4, 4, 8'h00, 8'h09};
        vecs[2] = '{4, 0, 'h20, 1, 4, 4, 8'h20, 8'h23};
        vecs[3] = '{0, 1, 'h00, 1, 0, 0, 8'h00, 8'h00};
        vecs[4] = '{1, 2, 'h40, 2, 1, 1, 8'h40, 8'h40};
        vecs[5] = '{3, 5, 'h50, 5, 3, 3, 8'h50, 8'h5A};

        srst_n = 1'b0; start = 1'b0; pkt_len = '0; skip = '0; ready = 1'b0;
        load_fifo(0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_sop", int'(sop), 0);
        chk("rst_eop", int'(eop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fifo_rd", int'(fifo_rd), 0);
        chk("rst_shift", int'(fifo_shift), 1);
        srst_n = 1'b1;

        // Vector table, ready held high
        for (int i = 0; i < 6; i++) begin
            load_fifo(vecs[i].base, 64, 1'b0);
            clear_stats();
            ready = 1'b1;
            start_pkt(vecs[i].len, vecs[i].skip);
            chk("vec_shift", int'(fifo_shift), vecs[i].exp_shift);
            wait_idle(200);
            chk("vec_pops", n_pops, vecs[i].exp_pops);
            chk("vec_words", n_words, vecs[i].exp_words);
            chk("vec_done", n_done, 1);
            if (vecs[i].exp_words > 0) begin
                chk("vec_first", int'(first_w), int'(vecs[i].exp_first));
                chk("vec_last", int'(last_w), int'(vecs[i].exp_last));
            end
        end

        // Back-pressure: at most two pops, head held
        load_fifo('h10, 64, 1'b0);
        clear_stats();
        ready = 1'b0;
        start_pkt(5, 1);
        repeat (6) cycle();
        chk("bp_pops", n_pops, 2);
        chk("bp_fifo_rd", int'(fifo_rd), 0);
        chk("bp_data", int'(data), 'h10);
        ready = 1'b1;
        wait_idle(200);
        chk("bp_words", n_words, 5);
        chk("bp_last", int'(last_w), 'h14);
        chk("bp_done", n_done, 1);

        // FIFO empty mid-packet, plus a start pulse while busy
        load_fifo('h30, 3, 1'b0);
        clear_stats();
        ready = 1'b1;
        start_pkt(6, 1);
        repeat (3) cycle();
        pkt_len = 8'd9;
        start   = 1'b1;
        cycle();
        start   = 1'b0;
        repeat (2) cycle();
        chk("empty_pops", n_pops, 3);
        wr_ptr = 64;
        drive_fifo();
        wait_idle(200);
        chk("empty_total_pops", n_pops, 6);
        chk("empty_last", int'(last_w), 'h35);
        chk("empty_done", n_done, 1);

        // Reset with two words buffered
        load_fifo('h60, 64, 1'b0);
        clear_stats();
        ready = 1'b0;
        start_pkt(5, 2);
        repeat (3) cycle();
        srst_n = 1'b0;
        cycle();
        srst_n = 1'b1;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_sop", int'(sop), 0);
        chk("mid_rst_eop", int'(eop), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_shift", int'(fifo_shift), 1);
        chk("mid_rst_pops", n_pops, 2);
        clear_stats();
        ready = 1'b1;
        start_pkt(2, 1);
        wait_idle(200);
        chk("post_rst_words", n_words, 2);
        chk("post_rst_first", int'(first_w), 'h64);
        chk("post_rst_done", n_done, 1);

        // Randomized packets, random ready and empty gaps
        rand_mode = 1'b1;
        for (int p = 0; p < 30; p++) begin
            load_fifo(0, MEMSZ, 1'b1);
            clear_stats();
            rlen = int'($urandom_range(0, 20));
            start_pkt(rlen, int'($urandom_range(0, 4)));
            wait_idle(2000);
            chk("rand_words", n_words, rlen);
            chk("rand_done", n_done, 1);
        end
        rand_mode   = 1'b0;
        force_empty = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
